// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: computes valE, holds the ZF/SF/OF condition codes, evaluates Cnd and
// registers the results into the E->M pipeline register behind a valid/ready handshake.
module y86_execute_stage #(
  parameter int unsigned W          = 64,
  parameter int unsigned STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         m_exc,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_icode,
  input  logic [3:0]   in_ifun,
  input  logic [W-1:0] in_valA,
  input  logic [W-1:0] in_valB,
  input  logic [W-1:0] in_valC,
  input  logic [3:0]   in_dstE,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_valE,
  output logic [W-1:0] out_valA,
  output logic [3:0]   out_dstE,
  output logic         out_cnd,
  output logic [2:0]   cc
);

  localparam logic [W-1:0] StackStep = W'(STACK_STEP);

  logic         accept;
  logic [W-1:0] add_a, add_b, add_sum, vale;
  logic         add_cin;
  logic         is_opq, op_ok, cc_we;
  logic         zf_new, sf_new, of_new;
  logic         zf, sf, of_flag, cond, cnd_eff;
  logic [3:0]   dste_eff;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign is_opq = (in_icode == 4'h6);
  assign op_ok  = (in_ifun <= 4'h3);
  assign cc_we  = accept && is_opq && op_ok && !m_exc;

  // Single shared adder; subtraction is valB + ~x + 1.
  assign add_sum = add_a + add_b + W'(add_cin);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    vale    = '0;
    unique case (in_icode)
      4'h2: begin
        add_a = in_valA;
        vale  = add_sum;
      end
      4'h3: begin
        add_a = in_valC;
        vale  = add_sum;
      end
      4'h4, 4'h5: begin
        add_a = in_valB;
        add_b = in_valC;
        vale  = add_sum;
      end
      4'h6: begin
        add_a = in_valB;
        unique case (in_ifun)
          4'h0: begin
            add_b = in_valA;
            vale  = add_sum;
          end
          4'h1: begin
            add_b   = ~in_valA;
            add_cin = 1'b1;
            vale    = add_sum;
          end
          4'h2:    vale = in_valB & in_valA;
          4'h3:    vale = in_valB ^ in_valA;
          default: vale = '0;
        endcase
      end
      4'h8, 4'hA: begin
        add_a   = in_valB;
        add_b   = ~StackStep;
        add_cin = 1'b1;
        vale    = add_sum;
      end
      4'h9, 4'hB: begin
        add_a = in_valB;
        add_b = StackStep;
        vale  = add_sum;
      end
      default: vale = '0;
    endcase
  end

  always_comb begin
    zf_new = (vale == '0);
    sf_new = vale[W-1];
    of_new = 1'b0;
    if (in_ifun == 4'h0) begin
      of_new = (in_valA[W-1] == in_valB[W-1]) && (vale[W-1] != in_valB[W-1]);
    end else if (in_ifun == 4'h1) begin
      of_new = (in_valA[W-1] != in_valB[W-1]) && (vale[W-1] != in_valB[W-1]);
    end
  end

  // Cnd uses the flags as they stand before this instruction's own update.
  assign zf      = cc[2];
  assign sf      = cc[1];
  assign of_flag = cc[0];

  always_comb begin
    cond = 1'b0;
    unique case (in_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of_flag) | zf;
      4'h2:    cond = sf ^ of_flag;
      4'h3:    cond = zf;
      4'h4:    cond = !zf;
      4'h5:    cond = !(sf ^ of_flag);
      4'h6:    cond = !(sf ^ of_flag) && !zf;
      default: cond = 1'b0;
    endcase
  end

  assign cnd_eff  = ((in_icode == 4'h2) || (in_icode == 4'h7)) ? cond : 1'b0;
  assign dste_eff = ((in_icode == 4'h2) && !cond) ? 4'hF : in_dstE;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= 3'b100;
    end else if (cc_we) begin
      cc <= {zf_new, sf_new, of_new};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= 4'h1;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= 4'hF;
      out_cnd   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_icode <= in_icode;
      out_valE  <= vale;
      out_valA  <= in_valA;
      out_dstE  <= dste_eff;
      out_cnd   <= cnd_eff;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed bench for y86_execute_stage; expected E->M contents are queued at acceptance and
// compared when the register fires into memory.
module tb_y86_execute_stage;

  logic        clk = 1'b0;
  logic        rst, flush, m_exc, in_valid, in_ready, out_valid, out_ready, out_cnd;
  logic [3:0]  in_icode, in_ifun, in_dstE, out_icode, out_dstE;
  logic [63:0] in_valA, in_valB, in_valC, out_valE, out_valA;
  logic [2:0]  cc;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic        cnd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  y86_execute_stage #(.W(64), .STACK_STEP(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .m_exc(m_exc),
    .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_valA(in_valA), .in_valB(in_valB), .in_valC(in_valC), .in_dstE(in_dstE),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valE(out_valE), .out_valA(out_valA), .out_dstE(out_dstE), .out_cnd(out_cnd),
    .cc(cc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory-stage side: compare each instruction as it leaves the E->M register.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_fire", 64'(out_icode), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_icode", 64'(out_icode), 64'(e.icode));
        chk("out_valE", out_valE, e.vale);
        chk("out_valA", out_valA, e.vala);
        chk("out_dstE", 64'(out_dstE), 64'(e.dste));
        chk("out_cnd", 64'(out_cnd), 64'(e.cnd));
      end
    end
  end

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] dst);
    in_valid = 1'b1;
    in_icode = ic;
    in_ifun  = fn;
    in_valA  = a;
    in_valB  = b;
    in_valC  = c;
    in_dstE  = dst;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic [3:0] dst,
                      input logic [63:0] ev, input logic [3:0] ed, input logic ecnd);
    int n = 0;
    drive(ic, fn, a, b, c, dst);
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back('{ic, ev, a, ed, ecnd});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_exc = 1'b0; out_ready = 1'b0;
    drive(4'h1, 4'h0, '0, '0, '0, 4'hF);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cc", 64'(cc), 64'b100);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_dstE", 64'(out_dstE), 64'hF);
    chk("rst_out_icode", 64'(out_icode), 64'h1);
    out_ready = 1'b1;

    // Sub overflow, then jl sees SF^OF=1.
    send(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, '0, 4'h2,
         64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 1'b0);
    chk("sub_cc", 64'(cc), 64'b001);
    send(4'h7, 4'h2, '0, '0, 64'h40, 4'hF, 64'd0, 4'hF, 1'b1);

    // Add wrap, then cmovne is squashed.
    send(4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, '0, 4'h1, 64'd0, 4'h1, 1'b0);
    chk("add_cc", 64'(cc), 64'b100);
    send(4'h2, 4'h4, 64'h55, '0, '0, 4'h3, 64'h55, 4'hF, 1'b0);

    // Backpressure: cmov stays in E->M, the next OPq must wait.
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 64'd2, 64'd3, '0, 4'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_cc", 64'(cc), 64'b100);
    end
    chk("bp_held_icode", 64'(out_icode), 64'h2);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    sb.push_back('{4'h6, 64'd5, 64'd2, 4'h4, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_cc_after", 64'(cc), 64'b000);

    // Invalid OPq passes through with valE=0 and no flag update.
    send(4'h6, 4'h4, 64'd5, 64'd5, '0, 4'h5, 64'd0, 4'h5, 1'b0);
    chk("inv_cc", 64'(cc), 64'b000);

    // Exception inhibits the CC write but not the transfer.
    m_exc = 1'b1;
    send(4'h6, 4'h3, 64'd5, 64'd5, '0, 4'h6, 64'd0, 4'h6, 1'b0);
    chk("exc_cc_hold", 64'(cc), 64'b000);
    m_exc = 1'b0;
    send(4'h6, 4'h3, 64'd5, 64'd5, '0, 4'h6, 64'd0, 4'h6, 1'b0);
    chk("xor_cc", 64'(cc), 64'b100);

    // Stack adjustment and a jg with ZF set.
    send(4'hA, 4'h0, 64'h77, 64'h100, '0, 4'h4, 64'hF8, 4'h4, 1'b0);
    send(4'hB, 4'h0, '0, 64'h100, '0, 4'h4, 64'h108, 4'h4, 1'b0);
    send(4'h7, 4'h6, '0, '0, 64'h80, 4'hF, 64'd0, 4'hF, 1'b0);
    chk("stack_cc", 64'(cc), 64'b100);

    // Flush blocks acceptance.
    @(posedge clk);
    #1;
    drive(4'hA, 4'h0, '0, 64'h200, '0, 4'h4);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);

    repeat (3) @(posedge clk);
    #1 chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_execute_stage.md
Name: y86_execute_stage

Overview:
- Execute stage of the Y86-64 pipeline, built on the 64-bit gate library (not64/and64/xor64) and the ALU adder.
- Takes a decoded instruction and computes valE. Holds the architectural condition-code register (ZF, SF, OF) and evaluates Cnd for jXX/cmovXX.
- Registers the results into the E->M pipeline register behind a valid/ready handshake.

Parameters:
- W, 64, datapath width; only 64 is supported.
- STACK_STEP, 8, stack-pointer adjustment for push/pop/call/ret.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill: clears the output register and blocks acceptance this cycle.
- m_exc  input  1  an exception is in flight in Memory/Writeback; inhibits the CC update.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_icode  input  4  Y86 icode.
- in_ifun  input  4  Y86 ifun.
- in_valA  input  W  operand A.
- in_valB  input  W  operand B.
- in_valC  input  W  immediate.
- in_dstE  input  4  destination register, passed through (0xF = none).
- out_valid  output  1  E->M register holds an instruction.
- out_ready  input  1  memory stage consumes.
- out_icode  output  4  registered icode.
- out_valE  output  W  registered result.
- out_valA  output  W  registered valA, passed through.
- out_dstE  output  4  registered dstE; forced to 0xF for a cmovXX whose Cnd=0.
- out_cnd  output  1  registered Cnd.
- cc  output  3  current {ZF, SF, OF}.

Behaviour:
- Reset: out_valid=0; out_icode=1 (nop); out_valE=0; out_valA=0; out_dstE=0xF; out_cnd=0; cc={1,0,0}.
- in_ready = !flush && (!out_valid || out_ready), purely combinational.
- Accept = in_valid && in_ready. Latency is 1 cycle: the result is visible on out_* the edge after acceptance.
- Register update priority: rst > flush > accept > hold.
  - flush: out_valid=0, no CC update.
  - Accept: load all out_*, out_valid=1.
  - Fire without accept (out_valid && out_ready): out_valid=0; other out_* hold their values.
  - Neither: hold everything.
- valE by icode:
  - 2 (rrmovq/cmov): valA+0.
  - 3 (irmovq): valC+0.
  - 4, 5 (rmmovq, mrmovq): valB+valC.
  - 6 (OPq), by ifun: 0 = valB+valA; 1 = valB-valA; 2 = valB&valA; 3 = valB^valA.
  - 8, A (call, pushq): valB-STACK_STEP.
  - 9, B (ret, popq): valB+STACK_STEP.
  - Others: 0.
- Arithmetic: all modulo 2^W, wrap-around silent. Subtraction is valB + not(valA) + 1 using not64 and the adder.
- OPq with ifun > 3: treated as invalid. valE=0, no CC update, instruction is still passed through.
- Flags from an OPq result r:
  - ZF = (r==0); SF = r[63].
  - add: OF = (A[63]==B[63]) && (r[63]!=B[63]).
  - sub: OF = (A[63]!=B[63]) && (r[63]!=B[63]).
  - and, xor: OF = 0.
- CC register is written on the edge of acceptance of a valid OPq (ifun 0-3) only when m_exc=0. With m_exc=1 the instruction is still accepted but cc holds.
- Cnd is computed from the cc value before the current instruction's update, by ifun:
  - 0: 1.
  - 1 (le): (SF^OF)|ZF.
  - 2 (l): SF^OF.
  - 3 (e): ZF.
  - 4 (ne): !ZF.
  - 5 (ge): !(SF^OF).
  - 6 (g): !(SF^OF) && !ZF.
  - Others: 0.
- out_cnd is meaningful for icode 2 and 7 only; it is 0 for every other icode.
- Back-to-back: an OPq accepted at edge N updates cc at edge N. A jXX accepted at edge N+1 therefore sees the new flags.
- Reset mid-transfer: the held instruction is discarded and cc is restored to {1,0,0}.

Test Plan:
- Reset check: rst high 2 cycles, then low -> out_valid=0, cc=3'b100, in_ready=1.
- Sub overflow: OPq sub, valA=1, valB=0x8000000000000000, out_ready=1 -> next cycle out_valE=0x7FFFFFFFFFFFFFFF, cc={0,0,1}. A following jXX ifun=2 (l) -> out_cnd=1.
- Add wrap: OPq add, valA=1, valB=0xFFFFFFFFFFFFFFFF -> out_valE=0, cc={1,0,0}. A following cmov ifun=4 (ne) with dstE=3 -> out_cnd=0, out_dstE=0xF.
- Backpressure: out_ready=0 while out_valid=1 -> in_ready=0; a second OPq is held off and cc is unchanged. Raising out_ready -> second instruction accepted the same cycle, one transfer per cycle.
- Exception inhibit: OPq xor, valA=valB=5 with m_exc=1 -> out_valE=0, cc unchanged. The same instruction with m_exc=0 -> cc={1,0,0}.
- Stack and flush: pushq valB=0x100 -> out_valE=0xF8; popq valB=0x100 -> out_valE=0x108. flush asserted together with in_valid -> not accepted, out_valid=0 next cycle.
